hlpte_input_loader: RTL and testbench
=====================================

// Module: hlpte_input_loader
// PURPOSE
// Front-end stage of HLPTE, sitting directly upstream of the transform/quant core.
// Packs the 16-frame 8-bit pixel stream (16 x 32x32 = 16384 px) into 32-bit frame-SRAM
// words. Deserialises each parameter set (index, 4 serial mode bits, QP) into one
// parallel command pulse for the core.
// PARAMETERS
// PIX_W       8      pixel width (bits)
// PACK        4      pixels per memory word; MEM_DW = PIX_W*PACK = 32
// FRAME_PIX   1024   pixels per frame (32x32)
// NUM_FRAMES  16     frames per pattern
// AW          12     word address width; log2(NUM_FRAMES*FRAME_PIX/PACK) = 4096 words
// PORTS
// clk             in   1      system clock; all logic on the rising edge
// rst             in   1      reset: asynchronous and active-high
// in_valid_data   in   1      pixel stream valid
// data            in   8      pixel, raster order, frame 0 first
// in_valid_param  in   1      parameter set valid; high for exactly 4 cycles
// index           in   4      target frame index; stable while in_valid_param is high
// mode            in   1      serial mode bit, MSB first (first bit -> cmd_mode[3])
// QP              in   5      quantisation parameter; stable while in_valid_param is high
// mem_we          out  1      frame-SRAM write strobe
// mem_addr        out  AW     word address = pixel_count / PACK
// mem_wdata       out  32     packed word; pixel k of the group in bits [8k+7:8k]
// load_done       out  1      1-cycle pulse: all 16384 pixels written
// cmd_valid       out  1      1-cycle pulse: cmd_* fields valid
// cmd_index       out  4      latched index
// cmd_mode        out  4      assembled mode bits
// cmd_qp          out  5      latched QP
// err             out  1      sticky: short burst or aborted parameter set
// BEHAVIOUR
// - Reset: every output and internal register goes to 0. pix_cnt=0, frames_ready=0,
//   FSM=P_IDLE. Reset applied mid-load or mid-param aborts the operation; no write or
//   pulse follows it.
// - Pixel path: 14-bit pix_cnt increments on each in_valid_data cycle.
//   * data goes into lane pix_cnt[1:0] of the pack register.
//   * When lane 3 is captured: next cycle mem_we=1, mem_addr=pix_cnt[13:2] (value
//     before the increment), mem_wdata=packed word. Latency is 1 cycle after the 4th
//     pixel.
//   * load_done is asserted together with the mem_we of word 4095. frames_ready is set;
//     pix_cnt wraps to 0, ready for the next pattern.
//   * Pixels beyond 16384 in the same burst are ignored: no write, counter held at 0.
//     The count re-arms when in_valid_data falls.
//   * in_valid_data falls with pix_cnt != 0 and != 16384: partial word discarded,
//     pix_cnt<=0, err<=1, frames_ready unchanged.
//   * A new burst while frames_ready=1 clears frames_ready on its first pixel.
// - Param FSM, states P_IDLE / P_SHIFT / P_ISSUE:
//   * P_IDLE: if in_valid_param && frames_ready, latch index/QP, put mode into
//     shift[3], bit_cnt<=1, go to P_SHIFT. If frames_ready=0, the set is ignored for all
//     4 cycles (no cmd_valid, err<=1).
//   * P_SHIFT: on valid, shift mode into the next lower bit and increment bit_cnt. When
//     the 4th bit is taken, go to P_ISSUE. If in_valid_param drops early: back to
//     P_IDLE, err<=1, no cmd_valid.
//   * P_ISSUE: cmd_valid=1 for exactly one cycle, with cmd_* updated in that same cycle
//     (2 cycles after the last mode bit edge), then go to P_IDLE.
//   * cmd_* fields hold their value until the next issue.
// - in_valid_data and in_valid_param both high in one cycle: the pixel path proceeds,
//   the param set is rejected (err<=1).
// - err clears only on rst.
// STRUCTURE
// - Shared package hlpte_pkg: PIX_W, FRAME_PIX, NUM_FRAMES, AW, the param-state enum
//   (P_IDLE/P_SHIFT/P_ISSUE), and a cmd_t struct {index, mode[3:0], qp}.
// - One sub-module, hlpte_pixel_packer: lane register, pix_cnt, write strobe and
//   load_done. The param FSM stays in the top level.
// TESTING
// - 16384 px with data=i%256 -> 4096 writes; word 0 = 32'h03020100; word 4095 at
//   addr 12'hFFF = 32'hFFFEFDFC; load_done coincides with the last mem_we.
// - After load: index=5, mode bits 1,0,1,1, QP=17 -> one cmd_valid, cmd_index=5,
//   cmd_mode=4'b1011, cmd_qp=17, err=0.
// - in_valid_param drops after 2 bits -> no cmd_valid, err=1; a following full set
//   still issues.
// - Param set before any load -> no cmd_valid, err=1.
// - Burst of 1030 px then drop -> 257 writes, no write for px 1028-1029, err=1, next
//   full burst starts at addr 0.
// - rst pulse at px 700 -> all outputs 0 the same cycle; reload from addr 0 passes;
//   16400-px burst -> only 4096 writes.

Source files
------------

// File: rtl/hlpte_pkg.sv
// hlpte_pkg: shared widths, param-FSM states and command record for the HLPTE front end
package hlpte_pkg;
  localparam int PIX_W = 8;
  localparam int PACK = 4;
  localparam int MEM_DW = PIX_W * PACK;
  localparam int FRAME_PIX = 1024;
  localparam int NUM_FRAMES = 16;
  localparam int AW = 12;
  localparam int CW = $clog2(NUM_FRAMES * FRAME_PIX);
  typedef enum logic [1:0] {P_IDLE, P_SHIFT, P_ISSUE} pstate_t;
  typedef struct packed {
    logic [3:0] index;
    logic [3:0] mode;
    logic [4:0] qp;
  } cmd_t;
endpackage

// File: rtl/hlpte_pixel_packer.sv
// hlpte_pixel_packer: packs 4 pixels per SRAM word, counts one 16-frame pattern, flags short bursts
module hlpte_pixel_packer
  import hlpte_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [PIX_W-1:0]  data,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic              load_done,
  output logic              frames_ready,
  output logic              short_burst
);
  logic [CW-1:0] pix_cnt;
  logic [MEM_DW-PIX_W-1:0] lanes;
  logic full, take, last;
  assign take = valid && !full;
  assign last = take && &pix_cnt;
  // bursts always restart word-aligned, so shifting lanes in is the same as indexing by pix_cnt[1:0]
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_cnt      <= '0;
      lanes        <= '0;
      full         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_done    <= 1'b0;
      frames_ready <= 1'b0;
      short_burst  <= 1'b0;
    end else begin
      mem_we       <= take && &pix_cnt[1:0];
      load_done    <= last;
      short_burst  <= !valid && |pix_cnt;
      full         <= valid && (full || last);
      frames_ready <= last ? 1'b1 : (take && ~|pix_cnt) ? 1'b0 : frames_ready;
      pix_cnt      <= take ? pix_cnt + 1'b1 : valid ? pix_cnt : '0;
      if (take) lanes <= {data, lanes[MEM_DW-PIX_W-1:PIX_W]};
      if (take && &pix_cnt[1:0]) begin
        mem_addr  <= pix_cnt[CW-1:2];
        mem_wdata <= {data, lanes};
      end
    end
endmodule

// File: rtl/hlpte_input_loader.sv
// hlpte_input_loader: pixel-to-SRAM packer plus serial parameter-set deserialiser for the HLPTE core
module hlpte_input_loader
  import hlpte_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_data,
  input  logic [PIX_W-1:0]  data,
  input  logic              in_valid_param,
  input  logic [3:0]        index,
  input  logic              mode,
  input  logic [4:0]        QP,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic              load_done,
  output logic              cmd_valid,
  output logic [3:0]        cmd_index,
  output logic [3:0]        cmd_mode,
  output logic [4:0]        cmd_qp,
  output logic              err
);
  pstate_t state;
  cmd_t pend, cmd;
  logic [1:0] bit_cnt;
  logic prev_param, frames_ready, short_burst, start, accept, reject;
  hlpte_pixel_packer u_packer (
    .clk(clk), .rst(rst), .valid(in_valid_data), .data(data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_done(load_done), .frames_ready(frames_ready), .short_burst(short_burst)
  );
  // a set is only recognised on the rising edge of its valid, so a rejected set stays ignored to its end
  assign start  = in_valid_param && !prev_param;
  assign accept = state == P_IDLE && start && frames_ready && !in_valid_data;
  assign reject = (state == P_IDLE && start && !accept) ||
                  (state == P_SHIFT && (!in_valid_param || in_valid_data));
  assign {cmd_index, cmd_mode, cmd_qp} = cmd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= P_IDLE;
      pend       <= '0;
      cmd        <= '0;
      bit_cnt    <= '0;
      prev_param <= 1'b0;
      cmd_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_param <= in_valid_param;
      cmd_valid  <= state == P_ISSUE;
      err        <= err || reject || short_burst;
      if (state == P_ISSUE) cmd <= pend;
      if (accept) begin
        pend    <= '{index: index, mode: {3'b000, mode}, qp: QP};
        bit_cnt <= 2'd1;
      end else if (state == P_SHIFT && !reject) begin
        pend.mode <= {pend.mode[2:0], mode};
        bit_cnt   <= bit_cnt + 2'd1;
      end
      state <= accept ? P_SHIFT :
               reject ? P_IDLE :
               (state == P_SHIFT && &bit_cnt) ? P_ISSUE :
               state == P_ISSUE ? P_IDLE : state;
    end
endmodule

// File: tb/tb_hlpte_input_loader.sv
// tb_hlpte_input_loader: table and random checks of pixel packing and parameter deserialisation
module tb_hlpte_input_loader;
  logic clk = 0, rst = 1, in_valid_data = 0, in_valid_param = 0, mode = 0;
  logic [7:0] data = 0;
  logic [3:0] index = 0;
  logic [4:0] QP = 0;
  logic mem_we, load_done, cmd_valid, err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] cmd_index, cmd_mode;
  logic [4:0] cmd_qp;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [11:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0] px[$];
  int ld_cnt = 0, cv_cnt = 0, cv_cyc = 0;
  bit ld_ok = 0, fr = 0, err_exp = 0;
  logic [12:0] cv_f = 0;
  typedef struct {
    int nb;
    logic [3:0] idx;
    logic [3:0] bits;
    logic [4:0] qp;
    bit iss;
  } pvec_t;
  pvec_t tbl[4];

  hlpte_input_loader dut (
    .clk(clk), .rst(rst), .in_valid_data(in_valid_data), .data(data),
    .in_valid_param(in_valid_param), .index(index), .mode(mode), .QP(QP),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_done(load_done),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_mode(cmd_mode), .cmd_qp(cmd_qp),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (load_done) begin
      ld_cnt++;
      ld_ok = mem_we && mem_addr == 12'hFFF;
    end
    if (cmd_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
      cv_f = {cmd_index, cmd_mode, cmd_qp};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [60:0] outs();
    return {mem_we, mem_addr, mem_wdata, load_done, cmd_valid, cmd_index, cmd_mode, cmd_qp, err};
  endfunction

  // drives n pixels back to back then drops valid; seq selects i%256 data, else random
  task automatic burst(input int n, input bit seq);
    wa.delete(); wd.delete(); px.delete();
    ld_cnt = 0; ld_ok = 0;
    for (int i = 0; i < n; i++) begin
      in_valid_data = 1;
      data = seq ? 8'(i % 256) : 8'($urandom);
      px.push_back(data);
      @(posedge clk); #1;
    end
    in_valid_data = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // reference: every complete group of 4 among the first 16384 pixels is one word at its group address
  task automatic check_burst(input string name, input int n);
    int m, nw, bad;
    m = n < 16384 ? n : 16384;
    nw = m / 4;
    bad = 0;
    for (int g = 0; g < wa.size() && g < nw; g++)
      if (wa[g] !== 12'(g) || wd[g] !== {px[4*g+3], px[4*g+2], px[4*g+1], px[4*g]}) bad++;
    chk({name, " writes"}, wa.size(), nw);
    chk({name, " word data/addr errors"}, bad, 0);
    chk({name, " load_done count"}, ld_cnt, n >= 16384);
    if (n >= 16384) chk({name, " load_done with last write"}, ld_ok, 1);
    if (n > 0) fr = n >= 16384;
    if (n > 0 && n < 16384) err_exp = 1;
    chk({name, " err"}, err, err_exp);
  endtask

  task automatic param(input string name, input int nb, input logic [3:0] idx, input logic [3:0] bits,
                       input logic [4:0] qp, input bit with_data, input bit iss);
    int c0, last;
    c0 = cv_cnt;
    last = 0;
    for (int k = 0; k < nb; k++) begin
      in_valid_param = 1; index = idx; QP = qp; mode = bits[3-k];
      in_valid_data = with_data && k == 0; data = 8'h00;
      @(posedge clk); #1;
      last = cyc;
    end
    in_valid_param = 0; in_valid_data = 0; mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk({name, " cmd_valid pulses"}, cv_cnt - c0, iss);
    if (iss) begin
      chk({name, " cmd fields"}, cv_f, {idx, bits, qp});
      chk({name, " cmd latency"}, cv_cyc, last + 1);
    end else err_exp = 1;
    if (with_data) fr = 0;
    chk({name, " err"}, err, err_exp);
  endtask

  initial begin
    tbl[0] = '{nb: 4, idx: 4'd5, bits: 4'b1011, qp: 5'd17, iss: 1};
    tbl[1] = '{nb: 2, idx: 4'd3, bits: 4'b1100, qp: 5'd9, iss: 0};
    tbl[2] = '{nb: 4, idx: 4'd12, bits: 4'b0110, qp: 5'd31, iss: 1};
    tbl[3] = '{nb: 3, idx: 4'd1, bits: 4'b0001, qp: 5'd2, iss: 0};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset outputs", outs(), 0);
    param("pre-load set", 4, 4'd2, 4'b1010, 5'd4, 0, 0);
    rst = 1; @(posedge clk); #1 rst = 0; err_exp = 0;

    burst(16384, 1);
    check_burst("seq load", 16384);
    if (wa.size() == 4096) begin
      chk("word0", wd[0], 32'h03020100);
      chk("last addr", wa[4095], 12'hFFF);
      chk("last word", wd[4095], 32'hFFFEFDFC);
    end
    for (int i = 0; i < 4; i++)
      param($sformatf("table%0d", i), tbl[i].nb, tbl[i].idx, tbl[i].bits, tbl[i].qp, 0, tbl[i].iss);
    for (int i = 0; i < 8; i++) begin
      int nb;
      nb = $urandom_range(2, 4);
      param($sformatf("rand%0d", i), nb, 4'($urandom), 4'($urandom), 5'($urandom), 0, nb == 4 && fr);
    end

    burst(1030, 0);
    check_burst("short burst", 1030);
    burst(16384, 0);
    check_burst("reload", 16384);

    for (int i = 0; i < 700; i++) begin
      in_valid_data = 1; data = 8'($urandom);
      @(posedge clk); #1;
    end
    #1 rst = 1;
    #1 chk("async rst outputs", outs(), 0);
    in_valid_data = 0;
    @(posedge clk); #1 rst = 0;
    err_exp = 0; fr = 0;
    wa.delete();
    repeat (5) @(posedge clk);
    #1 chk("writes after rst", wa.size(), 0);
    burst(16384, 0);
    check_burst("post-rst load", 16384);
    burst(16400, 0);
    check_burst("overlong burst", 16400);

    wa.delete();
    param("set with pixel", 4, 4'd9, 4'b0101, 5'd3, 1, 0);
    chk("set with pixel writes", wa.size(), 0);
    param("set after conflict", 4, 4'd6, 4'b1001, 5'd8, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
